// File: rtl/uart_rx_fifo_less_v2.sv
// UART receive engine with a single valid/ready holding register.
// The frame format is set by DATA_BITS, OVERSAMPLE and STOP_BITS.
// Define UART_RX_PARITY_EN to add a parity bit, checked against PARITY_ODD.
// Without that macro, parity_err is tied low and PARITY_ODD has no effect.
module uart_rx_fifo_less_v2 #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 rx_data,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd  = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic                 r_sync1, r_sync2;
  logic                 w_rx_s;
  state_e               r_state, w_state_next;
  logic [TickW-1:0]     r_tick;
  logic [BitW-1:0]      r_nbits;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_acc, r_brk_acc;
  logic                 w_mid, w_end, w_done, w_load;
  logic                 w_ferr_new, w_brk_new;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_break, r_overrun;

  assign w_rx_s = r_sync2;

  // Two-flop synchroniser; resets to idle-high so reset never fakes a start edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_data;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic; every transition except IDLE->START waits for a sample tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (!w_rx_s) w_state_next = StStart;
      StStart: if (w_mid) w_state_next = w_rx_s ? StIdle : StData;
      StData: begin
        if (w_end && (r_nbits == BitLast)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = StParity;
`else
          w_state_next = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (w_end) w_state_next = StStop;
`endif
      StStop:  if (w_end && (r_nbits == StopLast)) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Decoded strobes: sample points, frame completion and the flag values to be loaded.
  always_comb begin
    w_mid      = sample_tick && (r_tick == TickMid);
    w_end      = sample_tick && (r_tick == TickEnd);
    w_done     = (r_state == StStop) && w_end && (r_nbits == StopLast);
    w_load     = w_done && (!r_valid || rx_ready);
    w_ferr_new = r_ferr_acc | ~w_rx_s;
    // Break looks only at the first stop sample, which is taken when the stop counter is 0.
    w_brk_new  = (r_nbits == '0) ? ((r_shift == '0) & ~w_rx_s) : r_brk_acc;
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr_acc;
`endif

  // Counters, shift register and per-frame error accumulators.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tick     <= '0;
      r_nbits    <= '0;
      r_shift    <= '0;
      r_ferr_acc <= 1'b0;
      r_brk_acc  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_acc <= 1'b0;
`endif
    end else if (r_state == StIdle) begin
      r_tick  <= '0;
      r_nbits <= '0;
    end else if (sample_tick) begin
      case (r_state)
        StStart: begin
          r_tick <= w_mid ? '0 : r_tick + 1'b1;
          if (w_mid) begin
            r_nbits    <= '0;
            r_ferr_acc <= 1'b0;
            r_brk_acc  <= 1'b0;
          end
        end
        StData: begin
          r_tick <= w_end ? '0 : r_tick + 1'b1;
          if (w_end) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_nbits <= (r_nbits == BitLast) ? '0 : r_nbits + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          r_tick <= w_end ? '0 : r_tick + 1'b1;
          if (w_end) r_perr_acc <= (((^r_shift) ^ w_rx_s) != PARITY_ODD);
        end
`endif
        StStop: begin
          r_tick <= w_end ? '0 : r_tick + 1'b1;
          if (w_end) begin
            r_ferr_acc <= w_ferr_new;
            r_brk_acc  <= w_brk_new;
            r_nbits    <= (r_nbits == StopLast) ? '0 : r_nbits + 1'b1;
          end
        end
        default: r_tick <= '0;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
`endif

  // Holding register: load on completion unless full and not being drained.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= w_done && r_valid && !rx_ready;
      if (w_load) begin
        r_data      <= r_shift;
        r_valid     <= 1'b1;
        r_frame_err <= w_ferr_new;
        r_break     <= w_brk_new;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= r_perr_acc;
`endif
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out    = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign break_det   = r_break;
  assign overrun_err = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_less_v2.sv
// Directed bench for uart_rx_fifo_less_v2: default 8-bit / x16 / 1-stop instance plus a
// 2-stop-bit instance sharing the same serial line. Parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo_less_v2;

  localparam int Os = 16;

  logic       CLK, RESET_N, rx_data, sample_tick, rx_ready, rdy2;
  logic [7:0] data_out, data_out2;
  logic       rx_valid, frame_err, parity_err, break_det, overrun_err;
  logic       rx_valid2, frame_err2, parity_err2, break_det2, overrun_err2;

  int n_checks = 0;
  int n_fails  = 0;

  // Monitor state
  int         n_valid = 0, n_frames = 0, n_ovr = 0, n_frames2 = 0;
  logic [7:0] cap_data = '0, cap_data2 = '0;
  logic       cap_fe = 0, cap_pe = 0, cap_bd = 0, cap_fe2 = 0, cap_bd2 = 0;

  uart_rx_fifo_less_v2 dut (
    .CLK(CLK), .RESET_N(RESET_N), .rx_data(rx_data), .sample_tick(sample_tick),
    .data_out(data_out), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
    .overrun_err(overrun_err)
  );

  uart_rx_fifo_less_v2 #(.STOP_BITS(2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .rx_data(rx_data), .sample_tick(sample_tick),
    .data_out(data_out2), .rx_valid(rx_valid2), .rx_ready(rdy2),
    .frame_err(frame_err2), .parity_err(parity_err2), .break_det(break_det2),
    .overrun_err(overrun_err2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One sample_tick every 4 clocks, driven on the falling edge.
  initial begin
    int tcnt;
    tcnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge CLK);
      sample_tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  // Record handshakes, valid cycles and overrun pulses away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (rx_valid) n_valid++;
      if (overrun_err) n_ovr++;
      if (rx_valid && rx_ready) begin
        n_frames++;
        cap_data = data_out;
        cap_fe   = frame_err;
        cap_pe   = parity_err;
        cap_bd   = break_det;
      end
      if (rx_valid2 && rdy2) begin
        n_frames2++;
        cap_data2 = data_out2;
        cap_fe2   = frame_err2;
        cap_bd2   = break_det2;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (!sample_tick) @(posedge CLK);
    end
  endtask

  task automatic drive_bit(input logic b);
    #1 rx_data = b;
    wait_ticks(Os);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic s0,
                            input logic s1, input int ns);
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(s0);
    if (ns == 2) drive_bit(s1);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic do_reset();
    #1 rx_data = 1'b1;
    RESET_N = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    int f0, v0, o0;
    RESET_N  = 1'b0;
    rx_data  = 1'b1;
    rx_ready = 1'b1;
    rdy2     = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_parity_err", parity_err, 0);
    check_eq("rst_break", break_det, 0);
    check_eq("rst_overrun", overrun_err, 0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (4) @(posedge CLK);

    // Plain 0xA5 frame
    f0 = n_frames; v0 = n_valid;
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1, 1);
    check_eq("a5_frames", n_frames - f0, 1);
    check_eq("a5_valid_cycles", n_valid - v0, 1);
    check_eq("a5_data", cap_data, 8'hA5);
    check_eq("a5_frame_err", cap_fe, 0);
    check_eq("a5_parity_err", cap_pe, 0);
    check_eq("a5_break", cap_bd, 0);

    // False start: 4 ticks low is rejected at mid-start
    v0 = n_valid;
    wait_ticks(1);
    #1 rx_data = 1'b0;
    wait_ticks(4);
    #1 rx_data = 1'b1;
    wait_ticks(3 * Os);
    check_eq("false_start_no_valid", n_valid - v0, 0);
    f0 = n_frames;
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b1, 1);
    check_eq("3c_frames", n_frames - f0, 1);
    check_eq("3c_data", cap_data, 8'h3C);

    // Stop bit low
    f0 = n_frames;
    send_frame(8'h5A, ^8'h5A, 1'b0, 1'b1, 1);
    check_eq("5a_frames", n_frames - f0, 1);
    check_eq("5a_data", cap_data, 8'h5A);
    check_eq("5a_frame_err", cap_fe, 1);
    check_eq("5a_break", cap_bd, 0);
    do_reset();

    // Break: line low for 12 bit times
    f0 = n_frames;
    wait_ticks(1);
    #1 rx_data = 1'b0;
    wait_ticks(12 * Os);
    check_eq("brk_frames", n_frames - f0, 1);
    check_eq("brk_data", cap_data, 8'h00);
    check_eq("brk_frame_err", cap_fe, 1);
    check_eq("brk_break", cap_bd, 1);
    #1 rx_data = 1'b1;
    wait_ticks(4 * Os);
    do_reset();

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h11, ^8'h11, 1'b1, 1'b1, 1);
    @(negedge CLK);
    check_eq("ovr_first_valid", rx_valid, 1);
    check_eq("ovr_first_data", data_out, 8'h11);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b1, 1);
    @(negedge CLK);
    check_eq("ovr_pulses", n_ovr - o0, 1);
    check_eq("ovr_hold_data", data_out, 8'h11);
    check_eq("ovr_hold_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge CLK);
    check_eq("ovr_drain_valid", rx_valid, 0);
    check_eq("ovr_drain_data", data_out, 8'h11);

`ifdef UART_RX_PARITY_EN
    f0 = n_frames;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1);
    check_eq("par_bad_frames", n_frames - f0, 1);
    check_eq("par_bad_err", cap_pe, 1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1);
    check_eq("par_good_data", cap_data, 8'h01);
    check_eq("par_good_err", cap_pe, 0);
`endif

    // Reset asserted in the middle of data bit 4 of 0xFF
    f0 = n_frames;
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    #1 rx_data = 1'b1;
    wait_ticks(Os / 2);
    #1 RESET_N = 1'b0;
    wait_ticks(2);
    #1 RESET_N = 1'b1;
    wait_ticks(6 * Os);
    send_frame(8'h81, ^8'h81, 1'b1, 1'b1, 1);
    check_eq("rstmid_frames", n_frames - f0, 1);
    check_eq("rstmid_data", cap_data, 8'h81);
    check_eq("rstmid_frame_err", cap_fe, 0);
    check_eq("rstmid_break", cap_bd, 0);

    // Two stop bits on the second instance
    do_reset();
    f0 = n_frames2;
    send_frame(8'h96, ^8'h96, 1'b1, 1'b1, 2);
    check_eq("s2_good_frames", n_frames2 - f0, 1);
    check_eq("s2_good_data", cap_data2, 8'h96);
    check_eq("s2_good_frame_err", cap_fe2, 0);
    send_frame(8'h69, ^8'h69, 1'b1, 1'b0, 2);
    check_eq("s2_bad_data", cap_data2, 8'h69);
    check_eq("s2_bad_frame_err", cap_fe2, 1);
    check_eq("s2_bad_break", cap_bd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_less_v2.md
# uart_rx_fifo_less_v2

Parametrised UART receive engine, successor to the team's fixed 8N1 receiver. It adds:
- configurable frame format;
- input synchronisation and false-start rejection;
- per-frame error flags (framing, parity, break);
- a valid/ready output holding register with overrun reporting.

It sits between the board RX pin and the command parser of the gripper controller. It shares the baud-tick generator with the transmitter.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame, legal 5..9
- OVERSAMPLE, 16, sample_tick pulses per bit period, even, legal 8..32
- STOP_BITS, 1, stop bits checked, legal 1 or 2
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only with UART_RX_PARITY_EN)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- rx_data  in  1  raw serial line, idle high, asynchronous to CLK
- sample_tick  in  1  one-CLK-wide pulse at OVERSAMPLE × baud
- data_out  out  DATA_BITS  received payload, LSB received first
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts; handshake = rx_valid & rx_ready
- frame_err  out  1  a stop bit was sampled low (qualified by rx_valid)
- parity_err  out  1  parity mismatch (qualified by rx_valid; tied 0 without macro)
- break_det  out  1  all data bits and the first stop bit were sampled 0 (qualified by rx_valid)
- overrun_err  out  1  one-CLK pulse: completed frame discarded because the holding register was full

## Operation
- rx_data passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value rx_s.
- Tick counter: $clog2(OVERSAMPLE) bits. Bit counter: $clog2(DATA_BITS) bits. Both advance only on sample_tick.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: rx_s==0 → START, tick=0.
  - START: on the tick where tick==OVERSAMPLE/2-1, check rx_s:
    - rx_s==1 → IDLE (false start, nothing reported);
    - otherwise → DATA, tick=0, nbits=0.
  - DATA: on the tick where tick==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first). After DATA_BITS samples → PARITY with macro, else STOP.
  - PARITY: sample at tick==OVERSAMPLE-1. Error if XOR(data, parity bit) != PARITY_ODD.
  - STOP: sample each stop bit at tick==OVERSAMPLE-1. frame_err is set if any stop sample is 0. After the last stop sample → IDLE in the same cycle, and the frame completes.
- Frame completion with rx_valid==0, or with a handshake in the same cycle:
  - load data_out and the three flags;
  - set rx_valid.
- Frame completion with rx_valid==1 and rx_ready==0:
  - the new frame is discarded;
  - the holding register is unchanged;
  - overrun_err pulses for 1 CLK.
- Handshake without completion: rx_valid clears; data_out and the flags hold their last values.
- break_det implies frame_err.

## Timing
- Reset: state IDLE, all counters 0, data_out 0, rx_valid 0, all four flags 0, synchroniser 1.
- Reset asserted mid-frame aborts the frame immediately. The first frame after release needs a fresh falling edge.
- Pin-to-FSM latency: 2 CLK.
- rx_valid rises on the CLK edge that processes the last stop-bit sample_tick. Output is registered: data is visible the next cycle.
- Return to IDLE at mid-stop-bit. A following start edge is accepted immediately, so back-to-back frames lose nothing.
- Line low while in IDLE after a break: treated as a new start (the next break frame). Re-arming requires no idle period.
- sample_tick absent: the FSM freezes; it never times out.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present;
  - frame = start + DATA_BITS + parity + STOP_BITS;
  - parity_err is live and uses PARITY_ODD.
- Undefined:
  - PARITY state and its logic removed;
  - DATA goes directly to STOP;
  - parity_err is tied 0;
  - PARITY_ODD is ignored.

## Test plan
- Defaults, no macro, send 0xA5 8N1, rx_ready=1 → one rx_valid cycle, data_out=0xA5, all flags 0.
- rx_data low for 4 ticks then high → no state beyond START, rx_valid stays 0; a following 0x3C frame is received correctly.
- 0x5A with stop bit driven 0 → data_out=0x5A, frame_err=1, break_det=0. Line held low 12 bit times → data_out=0x00, frame_err=1, break_det=1.
- rx_ready=0, send 0x11 then 0x22 → data_out stays 0x11, overrun_err pulses once at the 0x22 stop sample. Raise rx_ready → rx_valid drops.
- Macro on, PARITY_ODD=0, send 0x01 with parity bit 0 → parity_err=1. Same frame with parity bit 1 → parity_err=0.
- Assert RESET_N low at data bit 4 of 0xFF, then release and send 0x81 → only 0x81 reported, flags 0. STOP_BITS=2 with second stop low → frame_err=1.
